// File: rtl/mux_rr_arb_n.sv
// CH-to-1 valid/ready channel merger with a registered output stage.
// Grant is fixed by sel (mode=0) or rotates fairly from rr_ptr (mode=1).
module mux_rr_arb_n #(
  parameter int W  = 8,
  parameter int CH = 8,
  parameter int SW = 3,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   xfer_cnt
);

  localparam logic [SW:0] CH_L = CH[SW:0];

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] xfer_cnt_q,  xfer_cnt_d;
  logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

  logic          load_en;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   rr_sum;
  logic          xfer;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin: scan offsets from the far end so the closest valid channel
  // after rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    if (!mode) begin
      if (({1'b0, sel} < CH_L) && in_valid[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      for (int i = CH - 1; i >= 0; i--) begin
        rr_sum = {1'b0, rr_ptr_q} + (SW+1)'(i);
        if (rr_sum >= CH_L) rr_sum = rr_sum - CH_L;
        if (in_valid[rr_sum[SW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_sum[SW-1:0];
        end
      end
    end
  end

  assign xfer     = grant_valid && load_en;
  assign in_ready = xfer ? (CH'(1) << grant_idx) : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = in_data[grant_idx*W +: W];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      xfer_cnt_d  = xfer_cnt_q + CW'(1);
      if (mode) rr_ptr_d = (grant_idx == SW'(CH - 1)) ? '0 : grant_idx + SW'(1);
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_rr_arb_n.sv
// Bench for mux_rr_arb_n: directed scenarios plus random traffic, all
// compared against a queue-free behavioural model of the merger.
module tb_mux_rr_arb_n;
  localparam int W = 8, CH = 8, SW = 3, CW = 4;

  logic            clk = 1'b0;
  logic            rst_n, mode, out_ready;
  logic [SW-1:0]   sel;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid, in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic [CW-1:0]   xfer_cnt;

  int tests = 0, fails = 0;

  // behavioural model state
  int m_valid = 0, m_data = 0, m_ch = 0, m_cnt = 0, m_ptr = 0;

  always #5 clk = ~clk;

  mux_rr_arb_n #(.W(W), .CH(CH), .SW(SW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int off = 0; off < CH; off++) begin
      int k;
      k = (m_ptr + off) % CH;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  // One clock: check the DUT against the model mid-cycle, then advance the model.
  task automatic cycle();
    int g, le, exp_rdy;
    @(negedge clk);
    g = model_grant();
    le = (m_valid == 0 || out_ready) ? 1 : 0;
    exp_rdy = (g >= 0 && le == 1) ? (1 << g) : 0;
    chk("m_out_valid", int'(out_valid), m_valid);
    chk("m_out_data",  int'(out_data),  m_data);
    chk("m_out_ch",    int'(out_ch),    m_ch);
    chk("m_xfer_cnt",  int'(xfer_cnt),  m_cnt);
    chk("m_in_ready",  int'(in_ready),  exp_rdy);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_cnt = 0; m_ptr = 0;
    end else if (le == 1) begin
      if (g >= 0) begin
        m_data = int'(in_data[g*W +: W]);
        m_ch = g;
        m_valid = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (mode) m_ptr = (g + 1) % CH;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_mult(input int base);
    for (int k = 0; k < CH; k++) in_data[k*W +: W] = W'(base * (k + 1));
  endtask

  int seq_exp[6] = '{0, 3, 7, 0, 3, 7};

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    // 1. reset and idle
    cycle(); cycle();
    rst_n = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_ch",    int'(out_ch),    0);
    chk("rst_xfer_cnt",  int'(xfer_cnt),  0);
    chk("rst_in_ready",  int'(in_ready),  0);
    cycle();

    // 2. fixed select
    set_data_mult(8'h11);
    in_data[5*W +: W] = 8'hA5;
    mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    #1 chk("fix_in_ready", int'(in_ready), 8'b0010_0000);
    cycle();
    chk("fix_out_data",  int'(out_data),  8'hA5);
    chk("fix_out_ch",    int'(out_ch),    5);
    chk("fix_out_valid", int'(out_valid), 1);
    cycle(); cycle();
    chk("fix_cnt3", int'(xfer_cnt), 3);
    sel = 3'd7; in_valid = 8'h7F;
    #1 chk("fix_sel7_rdy", int'(in_ready), 0);
    cycle();
    chk("fix_drain_valid", int'(out_valid), 0);
    chk("fix_drain_hold",  int'(out_data),  8'hA5);

    // 3. round-robin fairness
    mode = 1'b1; in_valid = 8'b1000_1001;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_seq", int'(out_ch), seq_exp[i]);
    end

    // 4. back-pressure
    in_valid = '0;
    cycle();
    set_data_mult(8'h11);
    in_valid = 8'hFF; out_ready = 1'b0;
    cycle();
    chk("bp_first_ch",   int'(out_ch),   0);
    chk("bp_first_data", int'(out_data), 8'h11);
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_in_ready", int'(in_ready), 0);
      cycle();
      chk("bp_hold_data",  int'(out_data),  8'h11);
      chk("bp_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_ch", int'(out_ch), 1);

    // 5. counter wrap and mid-operation reset
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    mode = 1'b0; sel = 3'd0; in_valid = 8'h01; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) cycle();
    chk("wrap_cnt", int'(xfer_cnt), 1);
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_cnt",   int'(xfer_cnt),  0);
    rst_n = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    cycle();
    chk("rst_rr_start", int'(out_ch), 0);

    // 6. mode switch keeps rr_ptr
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    mode = 1'b1; in_valid = 8'h04;
    cycle();
    chk("ms_rr_ch2", int'(out_ch), 2);
    mode = 1'b0; sel = 3'd6; in_valid = 8'hFF;
    #1 chk("ms_fix_rdy", int'(in_ready), 8'h40);
    cycle();
    chk("ms_fix_ch", int'(out_ch), 6);
    mode = 1'b1;
    #1 chk("ms_rr_rdy", int'(in_ready), 8'h08);
    cycle();
    chk("ms_rr_ch3", int'(out_ch), 3);

    // 7. random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 99) >= 3);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, CH - 1));
      in_valid  = CH'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      for (int k = 0; k < CH; k++) in_data[k*W +: W] = W'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
